// File: rtl/systolic_drain.sv
// Drain for a systolic array: one FIFO per column takes skewed column results,
// and the block emits whole rows in order (row 0 first) over a valid/ready port.
module systolic_drain #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [MATRIX_SIZE-1:0]              col_valid,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0]    col_data,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]    out_data,
  output logic [$clog2(MATRIX_SIZE)-1:0]      out_row,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow,
  output logic [1:0]                          o_dbg_state
);

  localparam int N  = MATRIX_SIZE;
  localparam int D  = DATA_SIZE;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [D-1:0]  r_mem    [N][N];
  logic [PW-1:0] r_wr_ptr [N];
  logic [PW-1:0] r_rd_ptr [N];
  logic [CW-1:0] r_cnt    [N];
  logic [CW-1:0] r_row_cnt;
  logic [CW-1:0] r_pop_cnt;

  logic          w_start_acc;
  logic          w_collect;
  logic          w_all_ne;
  logic          w_pop;
  logic          w_hs;
  logic          w_last_hs;
  logic [N-1:0]  w_wr;
  logic [N-1:0]  w_full;
  logic [N-1:0]  w_wr_ok;
  logic [N-1:0]  w_ovf_set;
  logic [N*D-1:0] w_row_data;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_start_acc = start && (r_state == S_IDLE);
  assign w_collect   = (r_state == S_COLLECT);
  // Row port: a row transfers on any cycle with out_valid && out_ready; while
  // out_valid is high and out_ready low, out_data and out_row hold.
  assign w_hs        = out_valid && out_ready;
  assign w_last_hs   = w_hs && (r_row_cnt == CW'(N - 1));

  always_comb begin
    w_all_ne   = 1'b1;
    w_wr       = '0;
    w_full     = '0;
    w_row_data = '0;
    for (int c = 0; c < N; c++) begin
      w_wr[c]   = col_valid[c] && w_collect;
      w_full[c] = (r_cnt[c] == CW'(N));
      if (r_cnt[c] == '0) w_all_ne = 1'b0;
      w_row_data[c*D +: D] = r_mem[c][r_rd_ptr[c]];
    end
    w_pop = w_collect && w_all_ne && (r_pop_cnt < CW'(N)) && (!out_valid || out_ready);
    w_wr_ok   = '0;
    w_ovf_set = '0;
    for (int c = 0; c < N; c++) begin
      // A full FIFO can still take a write when the same edge frees a slot.
      w_wr_ok[c]   = w_wr[c] && (!w_full[c] || w_pop);
      w_ovf_set[c] = w_wr[c] && w_full[c] && !w_pop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: if (w_last_hs) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state == S_COLLECT);
    done        = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      for (int c = 0; c < N; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_cnt[c]    <= '0;
      end
    end else if (w_start_acc) begin
      overflow <= 1'b0;
      for (int c = 0; c < N; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_cnt[c]    <= '0;
      end
    end else begin
      if (|w_ovf_set) overflow <= 1'b1;
      for (int c = 0; c < N; c++) begin
        if (w_wr_ok[c]) r_wr_ptr[c] <= inc_ptr(r_wr_ptr[c]);
        if (w_pop)      r_rd_ptr[c] <= inc_ptr(r_rd_ptr[c]);
        if (w_wr_ok[c] && !w_pop)      r_cnt[c] <= r_cnt[c] + CW'(1);
        else if (!w_wr_ok[c] && w_pop) r_cnt[c] <= r_cnt[c] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (w_wr_ok[c]) r_mem[c][r_wr_ptr[c]] <= col_data[c*D +: D];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      r_row_cnt <= '0;
      r_pop_cnt <= '0;
    end else begin
      if (w_start_acc) begin
        r_row_cnt <= '0;
        r_pop_cnt <= '0;
      end else begin
        if (w_hs)  r_row_cnt <= r_row_cnt + CW'(1);
        if (w_pop) r_pop_cnt <= r_pop_cnt + CW'(1);
      end
      if (w_pop) begin
        out_valid <= 1'b1;
        out_data  <= w_row_data;
        out_row   <= r_pop_cnt[PW-1:0];
      end else if (w_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: column writes feed a row-level reference model whose
// predicted rows go to a queue; a negedge monitor compares every presented row.
module tb_systolic_drain;

  localparam int N  = 2;
  localparam int D  = 32;
  localparam int W  = N * D;
  localparam int RW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  col_valid;
  logic [W-1:0]  col_data;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [RW-1:0] out_row;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [1:0]    o_dbg_state;

  systolic_drain #(.MATRIX_SIZE(N), .DATA_SIZE(D)) dut (
    .clk(clk), .reset(reset), .start(start), .col_valid(col_valid),
    .col_data(col_data), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_row(out_row), .busy(busy), .done(done),
    .overflow(overflow), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  logic [RW+W-1:0] exp_q[$];
  logic [D-1:0]    mcol[N][N];
  int              mcnt[N];
  int              rows_made;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) mcnt[c] = 0;
    rows_made = 0;
  endfunction

  // A column element lands in its column; any row that now has all columns becomes expected output.
  function automatic void model_write(input int c, input logic [D-1:0] v);
    logic [W-1:0] row;
    bit ok;
    if (mcnt[c] < N) begin
      mcol[c][mcnt[c]] = v;
      mcnt[c]++;
    end
    while (rows_made < N) begin
      ok = 1'b1;
      for (int k = 0; k < N; k++) if (mcnt[k] <= rows_made) ok = 1'b0;
      if (!ok) break;
      row = '0;
      for (int k = 0; k < N; k++) row[k*D +: D] = mcol[k][rows_made];
      exp_q.push_back({RW'(rows_made), row});
      rows_made++;
    end
  endfunction

  always @(negedge clk) begin
    logic [RW+W-1:0] front;
    if (!reset) begin
      if (done) done_seen++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_row actual_row=%0d actual_data=%0h expected=none", out_row, out_data);
        end else begin
          front = exp_q[0];
          chk("row_data", out_data, front[W-1:0]);
          chk("row_index", W'(out_row), W'(front[RW+W-1:W]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    @(negedge clk);
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_budget", W'(k < budget), W'(1));
    chk("busy_low_at_done", W'(busy), W'(0));
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_out_data"}, out_data, W'(0));
    chk({tag, "_out_row"}, W'(out_row), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_overflow"}, W'(overflow), W'(0));
    chk({tag, "_state"}, W'(o_dbg_state), W'(0));
  endtask

  task automatic idle_noise();
    col_valid = '1;
    col_data  = {$urandom, $urandom};
    tick();
    col_valid = '0;
    chk("idle_noise_no_valid", W'(out_valid), W'(0));
    chk("idle_noise_not_busy", W'(busy), W'(0));
  endtask

  task automatic random_body();
    int  sent[N];
    bit  did_start = 1'b0;
    bit  more = 1'b1;
    int  guard = 0;
    for (int c = 0; c < N; c++) sent[c] = 0;
    while (more && guard < 200) begin
      col_valid = '0;
      col_data  = {$urandom, $urandom};
      for (int c = 0; c < N; c++) begin
        if (sent[c] < N && $urandom_range(0, 1) == 1) begin
          col_valid[c] = 1'b1;
          col_data[c*D +: D] = $urandom;
          model_write(c, col_data[c*D +: D]);
          sent[c]++;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      start = (!did_start && $urandom_range(0, 3) == 0);
      if (start) did_start = 1'b1;
      tick();
      guard++;
      more = 1'b0;
      for (int c = 0; c < N; c++) if (sent[c] < N) more = 1'b1;
    end
    col_valid = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    wait_done(100);
    chk("rows_all_emitted", W'(exp_q.size()), W'(0));
  endtask

  task automatic random_job();
    int d0 = done_seen;
    model_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    random_body();
    chk("random_no_overflow", W'(overflow), W'(0));
    chk("random_one_done", W'(done_seen - d0), W'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int k;
    reset = 1'b1; start = 1'b0; col_valid = '0; col_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("in_reset");
    reset = 1'b0;
    tick();
    check_zero("after_reset");
    idle_noise();

    // Skewed drain with exact cycle timing
    model_reset();
    d0 = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("skew_busy", W'(busy), W'(1));
    col_valid = 2'b01; col_data = {32'h0, 32'hA0}; model_write(0, 32'hA0);
    tick();
    col_valid = 2'b11; col_data = {32'hB0, 32'hA1}; model_write(0, 32'hA1); model_write(1, 32'hB0);
    tick();
    col_valid = 2'b10; col_data = {32'hB1, 32'h0}; model_write(1, 32'hB1);
    @(negedge clk);
    chk("skew_not_yet_valid", W'(out_valid), W'(0));
    tick();
    col_valid = '0;
    @(negedge clk);
    chk("skew_row0_valid", W'(out_valid), W'(1));
    tick();
    @(negedge clk);
    chk("skew_row1_valid", W'(out_valid), W'(1));
    tick();
    @(negedge clk);
    chk("skew_done", W'(done), W'(1));
    chk("skew_busy_fall", W'(busy), W'(0));
    chk("skew_valid_fall", W'(out_valid), W'(0));
    tick();
    @(negedge clk);
    chk("skew_done_pulse", W'(done), W'(0));
    tick();
    chk("skew_one_done", W'(done_seen - d0), W'(1));
    chk("skew_rows_out", W'(exp_q.size()), W'(0));

    // Backpressure: row 0 held for three cycles
    model_reset();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    col_valid = 2'b11; col_data = {32'h1B0, 32'h1A0}; model_write(0, 32'h1A0); model_write(1, 32'h1B0);
    tick();
    col_valid = 2'b11; col_data = {32'h1B1, 32'h1A1}; model_write(0, 32'h1A1); model_write(1, 32'h1B1);
    tick();
    col_valid = '0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("bp_row_appears", W'(k < 10), W'(1));
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", W'(out_valid), W'(1));
      chk("bp_hold_row", W'(out_row), W'(0));
      tick();
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    wait_done(20);
    chk("bp_rows_out", W'(exp_q.size()), W'(0));

    // Overflow: three writes to column 0 with column 1 silent
    model_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    col_valid = 2'b01; col_data = {32'h0, 32'hC0}; model_write(0, 32'hC0);
    tick();
    chk("ovf_first", W'(overflow), W'(0));
    col_data = {32'h0, 32'hC1}; model_write(0, 32'hC1);
    tick();
    chk("ovf_second", W'(overflow), W'(0));
    col_data = {32'h0, 32'hC2};
    tick();
    chk("ovf_third", W'(overflow), W'(1));
    col_valid = '0;
    repeat (2) tick();
    chk("ovf_sticky", W'(overflow), W'(1));
    col_valid = 2'b10; col_data = {32'hD0, 32'h0}; model_write(1, 32'hD0);
    tick();
    col_data = {32'hD1, 32'h0}; model_write(1, 32'hD1);
    tick();
    col_valid = '0;
    wait_done(20);
    chk("ovf_sticky_after_done", W'(overflow), W'(1));
    model_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovf_clear_on_start", W'(overflow), W'(0));
    random_body();

    // Mid-job reset after one row
    model_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    col_valid = 2'b11; col_data = {32'hE0, 32'hF0}; model_write(0, 32'hF0); model_write(1, 32'hE0);
    tick();
    col_valid = 2'b01; col_data = {32'h0, 32'hF1}; model_write(0, 32'hF1);
    tick();
    col_valid = '0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mid_row0_appears", W'(k < 10), W'(1));
    tick();
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    check_zero("mid_after_reset");
    idle_noise();
    random_job();

    for (int j = 0; j < 20; j++) random_job();

    chk("final_queue_empty", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 2: array dimension N (rows = columns); legal values >= 2.
REQ-002 SHALL have parameter DATA_SIZE, default 32: bit width of one result element.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that opens one drain job.
REQ-006 SHALL have port col_valid, input, N bits: bit c flags a result element from array column c this cycle.
REQ-007 SHALL have port col_data, input, N*DATA_SIZE bits: column c element at bits [c*DATA_SIZE +: DATA_SIZE].
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds one deskewed result row.
REQ-010 SHALL have port out_data, output, N*DATA_SIZE bits: one result row, column c at bits [c*DATA_SIZE +: DATA_SIZE].
REQ-011 SHALL have port out_row, output, $clog2(N) bits: index of the row on out_data, 0 first.
REQ-012 SHALL have port busy, output, 1 bit: high while a job is open.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last row handshake.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag for a write to a full column buffer.

Function
REQ-015 SHALL implement states IDLE, COLLECT and DONE.
REQ-016 IDLE -> COLLECT on start; COLLECT -> DONE on the out_valid&&out_ready handshake of row N-1; DONE -> IDLE unconditionally after one cycle.
REQ-017 start in COLLECT or DONE SHALL be ignored.
REQ-018 Each column SHALL have an N-deep FIFO written on col_valid[c] only in COLLECT; col_valid in IDLE or DONE SHALL be discarded.
REQ-019 Elements per column SHALL arrive in row order 0..N-1 with arbitrary inter-column skew; the block SHALL NOT assume any fixed skew.
REQ-020 A row SHALL be popped (one entry from every FIFO) when all N FIFOs are non-empty and (out_valid==0 or out_ready==1).
REQ-021 A pop SHALL load out_data, out_row and out_valid=1 at the same edge; out_valid is high one cycle after the edge that wrote the row's last element.
REQ-022 While out_valid==1 and out_ready==0, out_data and out_row SHALL hold stable.
REQ-023 out_valid SHALL deassert after a handshake if no pop occurs in the same cycle; back-to-back rows SHALL sustain one row per cycle.
REQ-024 Simultaneous write and pop on one FIFO SHALL be legal, including when full; that write is not an overflow.
REQ-025 A write to a full FIFO without a simultaneous pop SHALL drop the element and set overflow.
REQ-026 overflow SHALL clear only on reset or on an accepted start.
REQ-027 The row counter SHALL be $clog2(N+1) bits, increment per handshake, clear on accepted start.
REQ-028 busy SHALL equal (state==COLLECT); done SHALL equal (state==DONE).
REQ-029 Accepted start SHALL clear all FIFO pointers and counts.

Reset
REQ-030 reset SHALL force IDLE, empty all FIFOs, and clear out_valid, out_data, out_row, busy, done, overflow and the row counter to 0, including mid-job.
REQ-031 After reset deassertion no output SHALL change until an accepted start.

Verification
REQ-032 Reset: assert reset at any time -> all outputs 0, state IDLE, next-cycle col_valid ignored.
REQ-033 Skewed drain (N=2, D=32, out_ready=1): start; col0=0xA0; next cycle col0=0xA1 and col1=0xB0; next col1=0xB1 -> rows {0xB0,0xA0} row0 then {0xB1,0xA1} row1 on consecutive cycles, done pulses once, busy falls with it.
REQ-034 Backpressure: out_ready=0 for 3 cycles while row0 valid -> out_valid, out_data, out_row stable; rows then emitted in order with no loss.
REQ-035 Overflow: in COLLECT write 3 elements to col0 while col1 idle -> overflow=1 on third write, sticky until next start.
REQ-036 Mid-job reset: reset after one row emitted -> outputs cleared; a new start then drains a full job correctly.
REQ-037 Ignored events: start during COLLECT and col_valid during IDLE -> no state, counter or FIFO change.
